// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tile read scheduler.
package tile_sched_pkg;

  // Sample width carried through the output buffer.
  localparam int unsigned SampleW   = 8;
  // Output buffer depth; the issue credit check relies on it being 2.
  localparam int unsigned FifoDepth = 2;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRecv,
    StRead,
    StDrain
  } state_e;

  typedef struct packed {
    logic [SampleW-1:0] data;
    logic               last;
    logic [1:0]         user;
  } entry_t;

  // Last pixel index of a tile, saturated to the 256-entry RAM.
  function automatic logic [7:0] calc_npix_last(input logic [7:0] w, input logic [7:0] h);
    logic [15:0] prod;
    prod = 16'(w) * 16'(h);
    if (prod > 16'd256) begin
      return 8'd255;
    end
    return 8'(prod - 16'd1);
  endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry register FIFO with first-word fall-through head and occupancy count.
module sample_fifo2
  import tile_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  // Next-state: write at wr_ptr, advance rd_ptr on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/tile_read_sched.sv
// Sequences one tile: arm RAM reception, wait for it, then stream channel planes out.
module tile_read_sched
  import tile_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = SampleW,
  parameter int unsigned FIFO_DEPTH = FifoDepth
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [7:0]       tile_width,
  input  logic [7:0]       tile_height,
  input  logic [1:0]       chan_last,
  output logic             busy,
  output logic             tile_done,
  output logic             ram_start_receive,
  input  logic             ram_receive_done,
  output logic [1:0]       rchannel,
  output logic             rvalid,
  output logic [7:0]       raddr,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [1:0]       m_axis_tuser
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] npix_last_q, npix_last_d;
  logic [1:0] ch_q, ch_d;
  logic [1:0] chan_last_q, chan_last_d;
  logic       inflight_q, inflight_d;
  logic       inflight_last_q, inflight_last_d;
  logic [1:0] inflight_user_q, inflight_user_d;

  logic [1:0] fifo_count;
  entry_t     fifo_head;
  entry_t     push_entry;
  logic       pop;
  logic       issue;
  logic       last_addr;
  logic [2:0] occupancy;

  // Credit check: buffered + in flight - leaving this cycle must leave a free slot.
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == StRead) && (occupancy < 3'(FIFO_DEPTH));
  assign last_addr = (addr_q == npix_last_q);

  assign push_entry = '{data: rdata, last: inflight_last_q, user: inflight_user_q};

  sample_fifo2 u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Final beat leaves the buffer with nothing behind it.
  assign tile_done = (state_q == StDrain) && !inflight_q && (fifo_count == 2'd1) && pop;

  // Next-state and read address sequencing.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    ch_d            = ch_q;
    npix_last_d     = npix_last_q;
    chan_last_d     = chan_last_q;
    inflight_d      = issue;
    inflight_last_d = last_addr;
    inflight_user_d = ch_q;
    unique case (state_q)
      StIdle: begin
        if (start && (tile_width != 8'd0) && (tile_height != 8'd0)) begin
          state_d     = StArm;
          npix_last_d = calc_npix_last(tile_width, tile_height);
          chan_last_d = chan_last;
          addr_d      = 8'd0;
          ch_d        = 2'd0;
        end
      end
      StArm: state_d = StRecv;
      StRecv: begin
        if (ram_receive_done) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (issue) begin
          if (last_addr) begin
            addr_d = 8'd0;
            if (ch_q == chan_last_q) begin
              ch_d    = 2'd0;
              state_d = StDrain;
            end else begin
              ch_d = ch_q + 2'd1;
            end
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end
      end
      StDrain: begin
        if (tile_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      addr_q          <= 8'd0;
      ch_q            <= 2'd0;
      npix_last_q     <= 8'd0;
      chan_last_q     <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_user_q <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      ch_q            <= ch_d;
      npix_last_q     <= npix_last_d;
      chan_last_q     <= chan_last_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      inflight_user_q <= inflight_user_d;
    end
  end

  assign busy              = (state_q != StIdle);
  assign ram_start_receive = (state_q == StArm);
  assign rvalid            = issue;
  assign raddr             = addr_q;
  assign rchannel          = ch_q;
  assign m_axis_tvalid     = (fifo_count != 2'd0);
  assign m_axis_tdata      = fifo_head.data;
  assign m_axis_tlast      = fifo_head.last;
  assign m_axis_tuser      = fifo_head.user;

endmodule

// File: tb/tb_tile_read_sched.sv
// Scoreboard bench for tile_read_sched with a behavioural RAM and reference read order.
module tb_tile_read_sched;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] user;
    logic       first;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tile_width = 8'd0;
  logic [7:0] tile_height = 8'd0;
  logic [1:0] chan_last = 2'd0;
  logic       busy, tile_done, ram_start_receive;
  logic       ram_receive_done = 1'b0;
  logic [1:0] rchannel;
  logic       rvalid;
  logic [7:0] raddr;
  logic [7:0] rdata = 8'd0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic [1:0] m_axis_tuser;

  tile_read_sched dut (
    .clk               (clk),
    .rstn              (rstn),
    .start             (start),
    .tile_width        (tile_width),
    .tile_height       (tile_height),
    .chan_last         (chan_last),
    .busy              (busy),
    .tile_done         (tile_done),
    .ram_start_receive (ram_start_receive),
    .ram_receive_done  (ram_receive_done),
    .rchannel          (rchannel),
    .rvalid            (rvalid),
    .raddr             (raddr),
    .rdata             (rdata),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser)
  );

  always #5 clk = ~clk;

  // Written by the stimulus process only.
  logic [31:0] mem [256];
  exp_t        exp_q[$];
  int          npix_last_m = 0;
  int          chan_last_m = 0;
  int          tready_mode = 0;
  logic        spurious_done = 1'b0;
  string       req_name = "";
  logic [31:0] req_act = '0;
  logic [31:0] req_exp = '0;
  int          req_seq = 0;

  // Written by the monitor only.
  int n_cmp = 0;
  int n_err = 0;
  int rd_idx = 0;
  int arm_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int first_hs_cyc = 0;
  int last_hs_cyc = 0;

  // Channel ch occupies byte lane 3-ch of the 32-bit RAM word (channel 0 in the top byte).
  function automatic logic [7:0] ram_byte(input logic [31:0] wd, input int ch);
    logic [31:0] s;
    s = wd >> (8 * (3 - ch));
    return s[7:0];
  endfunction

  // RAM read port: one-cycle latency.
  always @(posedge clk) begin
    if (rvalid) rdata <= ram_byte(mem[raddr], int'(rchannel));
  end

  // Input driver: downstream ready pattern and RAM receive-done responder.
  int phase = 0;
  int recv_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = (phase == 0) || (phase == 3);
        phase = (phase + 1) % 4;
      end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    ram_receive_done = spurious_done;
    if (!rstn) recv_cnt = 0;
    if (recv_cnt != 0) begin
      recv_cnt--;
      if (recv_cnt == 0) ram_receive_done = 1'b1;
    end
    if (ram_start_receive) recv_cnt = $urandom_range(1, 4);
  end

  // Monitor: scoreboard pops, stall stability, read range and posted checks.
  int   seen_seq = 0;
  logic prev_stall = 1'b0;
  logic [10:0] prev_beat = '0;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (req_seq != seen_seq) begin
      seen_seq = req_seq;
      n_cmp++;
      if (req_act !== req_exp) begin
        n_err++;
        $display("FAIL %s: got %0h, expected %0h", req_name, req_act, req_exp);
      end
    end
    if (!rstn) begin
      rd_idx     = exp_q.size();
      prev_stall = 1'b0;
    end else begin
      if (rvalid) begin
        n_cmp++;
        if (int'(raddr) > npix_last_m || int'(rchannel) > chan_last_m) begin
          n_err++;
          $display("FAIL read_range: got ch=%0d addr=%0d, expected ch<=%0d addr<=%0d",
                   rchannel, raddr, chan_last_m, npix_last_m);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser} !== prev_beat) begin
          n_err++;
          $display("FAIL stall_stable: got valid=%b beat=%h, expected valid=1 beat=%h",
                   m_axis_tvalid, {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_beat);
        end
      end
      if (ram_start_receive) arm_cnt++;
      if (tile_done) done_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (rd_idx >= exp_q.size()) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got data=%02h user=%0d, expected no beat",
                   m_axis_tdata, m_axis_tuser);
        end else begin
          e = exp_q[rd_idx];
          n_cmp++;
          if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
            n_err++;
            $display("FAIL beat %0d: got data=%02h last=%b user=%0d, expected data=%02h last=%b user=%0d",
                     rd_idx, m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
          end
          n_cmp++;
          if (tile_done !== e.done) begin
            n_err++;
            $display("FAIL tile_done_at_beat %0d: got %b, expected %b", rd_idx, tile_done, e.done);
          end
          if (e.first) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          rd_idx++;
        end
      end else if (tile_done) begin
        n_cmp++;
        n_err++;
        $display("FAIL tile_done_no_beat: got 1, expected 0");
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hand a comparison to the monitor and let it consume it.
  task automatic post(input string name, input logic [31:0] act, input logic [31:0] expv);
    req_name = name;
    req_act  = act;
    req_exp  = expv;
    req_seq++;
    @(negedge clk);
    #1;
  endtask

  int arm_base = 0;
  int done_base = 0;
  int tile_beats = 0;

  task automatic start_tile(input int w, input int h, input int cl, input bit pattern);
    int npix;
    for (int i = 0; i < 256; i++) mem[i] = pattern ? (32'hAA00_0000 | 32'(i)) : $urandom;
    npix = w * h;
    if (npix > 256) npix = 256;
    npix_last_m = npix - 1;
    chan_last_m = cl;
    tile_beats  = (cl + 1) * npix;
    for (int ch = 0; ch <= cl; ch++) begin
      for (int a = 0; a < npix; a++) begin
        exp_q.push_back('{data: ram_byte(mem[a], ch), last: (a == npix - 1), user: 2'(ch),
                          first: (ch == 0 && a == 0), done: (ch == cl && a == npix - 1)});
      end
    end
    arm_base    = arm_cnt;
    done_base   = done_cnt;
    tile_width  = 8'(w);
    tile_height = 8'(h);
    chan_last   = 2'(cl);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic finish_tile(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (!busy) break;
      tick();
    end
    if (i == 3000) post({name, "_idle_timeout"}, 32'(busy), 32'd0);
    post({name, "_all_beats"}, 32'(rd_idx), 32'(exp_q.size()));
    post({name, "_arm_pulses"}, 32'(arm_cnt - arm_base), 32'd1);
    post({name, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  initial begin
    int base;
    rstn = 1'b0;
    tick();
    tick();
    post("reset_outputs", 32'({busy, tile_done, ram_start_receive, rchannel, rvalid, raddr,
                               m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
    rstn = 1'b1;
    tick();

    // Done pulse while idle must not start anything.
    @(negedge clk);
    spurious_done = 1'b1;
    @(negedge clk);
    spurious_done = 1'b0;
    tick();
    tick();
    post("spurious_done_busy", 32'(busy), 32'd0);

    // 4x2, one channel, fixed pattern.
    tready_mode = 0;
    start_tile(4, 2, 0, 1'b1);
    finish_tile("t4x2");

    // 2x2, four channels, full throughput.
    start_tile(2, 2, 3, 1'b0);
    finish_tile("t2x2c4");
    post("t2x2c4_no_gaps", 32'(last_hs_cyc - first_hs_cyc), 32'(tile_beats - 1));

    // Same tile under 1,0,0,1 backpressure.
    tready_mode = 1;
    start_tile(2, 2, 3, 1'b0);
    finish_tile("t2x2c4_bp");

    // Oversized tile saturates to 256 pixels.
    tready_mode = 0;
    start_tile(16, 17, 0, 1'b0);
    finish_tile("t16x17");
    post("t16x17_no_gaps", 32'(last_hs_cyc - first_hs_cyc), 32'd255);

    // Zero dimension start is ignored.
    arm_base    = arm_cnt;
    tile_width  = 8'd0;
    tile_height = 8'd3;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    post("zero_dim_busy", 32'(busy), 32'd0);
    post("zero_dim_arm", 32'(arm_cnt - arm_base), 32'd0);

    // Start while reading is ignored.
    start_tile(3, 3, 1, 1'b0);
    for (int i = 0; i < 200 && !rvalid; i++) tick();
    tile_width  = 8'd5;
    tile_height = 8'd5;
    chan_last   = 2'd3;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    finish_tile("busy_start");

    // Reset after three beats discards the tile.
    start_tile(4, 4, 2, 1'b0);
    base = exp_q.size() - tile_beats;
    for (int i = 0; i < 500 && rd_idx < base + 3; i++) tick();
    rstn = 1'b0;
    #1;
    post("midreset_outputs", 32'({busy, tile_done, ram_start_receive, rchannel, rvalid, raddr,
                                  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    post("midreset_idle", 32'(busy), 32'd0);
    post("midreset_no_done", 32'(done_cnt - done_base), 32'd0);
    start_tile(3, 2, 1, 1'b0);
    finish_tile("after_reset");

    // Random tiles under random backpressure.
    tready_mode = 2;
    for (int k = 0; k < 5; k++) begin
      start_tile($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(0, 3), 1'b0);
      finish_tile("random");
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_read_sched.md
Name: tile_read_sched

Overview:
Controller that sequences one tile through the 32-bit x 256 pixel data RAM. It starts RAM reception, waits for the receive-done pulse, then reads the tile back one channel plane at a time: all pixels of channel 0, then channel 1, and so on. Each 8-bit sample is emitted on an AXI-Stream master with full backpressure support. It sits between the AXI-Stream input RAM and the downstream per-channel prediction/entropy stages.

Parameters:
WIDTH, 8, sample width; must match the RAM's per-channel width.
FIFO_DEPTH, 2, output buffer depth; fixed at 2, and the credit logic depends on this value.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle request to process one tile; ignored unless IDLE
tile_width  in  8  pixels per row; sampled on accepted start
tile_height  in  8  rows per tile; sampled on accepted start
chan_last  in  2  index of last channel to read (0..3); sampled on accepted start
busy  out  1  high whenever state is not IDLE
tile_done  out  1  one-cycle pulse when the final sample is accepted downstream
ram_start_receive  out  1  one-cycle pulse that re-arms RAM reception
ram_receive_done  in  1  one-cycle pulse from RAM when the tile is fully written
rchannel  out  2  channel select for the RAM read
rvalid  out  1  RAM read enable
raddr  out  8  RAM read address
rdata  in  WIDTH  RAM read data, valid one cycle after rvalid
m_axis_tdata  out  WIDTH  output sample
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  marks the last sample of each channel plane
m_axis_tuser  out  2  channel index of the sample

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Reset mid-operation discards everything. No tile_done is generated.
- States:
  - IDLE -> ARM on start when tile_width!=0 and tile_height!=0. Start with a zero dimension is ignored.
  - ARM: ram_start_receive=1 for exactly this one cycle -> RECV.
  - RECV: wait for ram_receive_done -> READ. A done pulse in any other state is ignored.
  - READ: issue reads. Once the last read has been issued -> DRAIN.
  - DRAIN: wait for the FIFO to empty and no read in flight. The cycle the final beat handshakes sets tile_done=1 -> IDLE.
- Capture on start:
  - npix_last = tile_width*tile_height-1, computed at 16 bits and clamped to 255.
  - chan_last is registered.
- Read order is channel-major: for ch = 0..chan_last, for addr = 0..npix_last. rchannel=ch and raddr=addr are driven with rvalid.
- Latency: rvalid in cycle t gives rdata in cycle t+1, which is written into the FIFO in t+1.
- Each FIFO entry carries {tdata, tlast, tuser}. tlast = (addr==npix_last) of the issuing read. tuser = ch.
- Issue rule: rvalid = (state==READ) && (count + inflight - pop) < 2.
  - inflight = rvalid registered one cycle.
  - pop = m_axis_tvalid && m_axis_tready.
  - This gives 1 sample/cycle with tready held high and never overflows the FIFO.
- Backpressure: m_axis_tdata/tlast/tuser stay stable while tvalid && !tready.
- Wrap: addr wraps to 0 and ch increments after npix_last. Read issue stops after (chan_last, npix_last).
- Simultaneous push and pop with count==2 is not reachable by construction. Push and pop in the same cycle keeps count unchanged.
- start while busy: ignored, no latch.

Decomposition:
- Package tile_sched_pkg holds:
  - state enum IDLE/ARM/RECV/READ/DRAIN
  - FIFO_DEPTH constant
  - entry struct {data, last, user}
- Sub-module: sample_fifo2, a 2-entry register FIFO with count output, push/pop, and first-word fall-through.
- Controller top is about 200 lines; FIFO is about 80 lines.

Test Plan:
- w=4, h=2, chan_last=0, tready=1, RAM word n = 0xAA000000|n:
  - ram_start_receive pulses once.
  - After done, 8 beats with tdata=0xAA, tuser=0.
  - tlast on beat 8.
  - tile_done in the same cycle as beat 8's handshake.
- w=2, h=2, chan_last=3, tready=1:
  - 16 beats, tuser sequence 0x4,1x4,2x4,3x4.
  - tlast on beats 4, 8, 12, 16.
  - No idle cycles between beats.
- Same tile with tready toggling 1,0,0,1 repeated:
  - Data stays stable while stalled.
  - FIFO count never exceeds 2.
  - No sample lost or duplicated (scoreboard vs expected order).
- w=16, h=17 (product 272):
  - npix_last clamps to 255.
  - 256 beats for channel 0.
  - raddr never exceeds 255.
- Zero dimension and busy cases:
  - start with w=0 -> stays IDLE, busy=0.
  - start pulsed during READ -> ignored, tile completes normally.
- Reset mid-operation:
  - rstn low during READ after 3 beats -> all outputs 0, state IDLE, no tile_done.
  - A subsequent tile runs cleanly.
